// File: rtl/profiler_readout.sv
// profiler_readout: snapshots a bank of 32-bit profiler counters on request
// and streams them out as a framed valid/ready sequence:
//   header {HEADER_TAG, 12'h0, NUM_COUNTERS[3:0]}, counter words 0..N-1,
//   then a checksum word (XOR of the header and every snapshot word).
// An optional one-cycle clear pulse is issued alongside the snapshot so the
// profiler can restart counting from zero. Requests that arrive while a
// frame is in flight are discarded and recorded in a sticky flag.
module profiler_readout #(
   parameter int unsigned NUM_COUNTERS = 10,
   parameter logic [15:0] HEADER_TAG   = 16'hABAC
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_COUNTERS*32-1:0]   counters_in,
   input  logic                         read_req,
   input  logic                         clear_on_read,
   output logic                         clear_counters,
   output logic [31:0]                  out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last,
   output logic                         busy,
   output logic                         req_dropped
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_HEADER   = 2'd1,
      S_DATA     = 2'd2,
      S_CHECKSUM = 2'd3
   } state_t;

   // The counter count is carried in the low nibble of the header, which is
   // why NUM_COUNTERS is limited to 15.
   localparam logic [3:0]  NUM_NIB     = 4'(NUM_COUNTERS);
   localparam logic [3:0]  LAST_IDX    = 4'(NUM_COUNTERS - 1);
   localparam logic [31:0] HEADER_WORD = {HEADER_TAG, 12'h000, NUM_NIB};

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [31:0] snap_q [NUM_COUNTERS];
   logic [31:0] snap_d [NUM_COUNTERS];
   logic [31:0] csum_q, csum_d;
   logic        clear_q, clear_d;
   logic        dropped_q, dropped_d;

   logic [31:0] live_xor;
   logic [31:0] data_word;
   logic        xfer;

   // A word moves whenever something is presented and downstream accepts it.
   assign xfer = (state_q != S_IDLE) && out_ready;

   // Checksum of the live counters folded with the header, captured together
   // with the snapshot so the trailer word is ready without a serial pass.
   always_comb begin
      live_xor = HEADER_WORD;
      for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
         live_xor = live_xor ^ counters_in[32*i +: 32];
      end
   end

   // Next-state, snapshot capture, clear pulse and drop-flag logic.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      csum_d    = csum_q;
      clear_d   = 1'b0;
      dropped_d = dropped_q;
      for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
         snap_d[i] = snap_q[i];
      end

      case (state_q)
         S_IDLE: begin
            if (read_req) begin
               state_d = S_HEADER;
               idx_d   = 4'd0;
               csum_d  = live_xor;
               clear_d = clear_on_read;
               for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
                  snap_d[i] = counters_in[32*i +: 32];
               end
            end
         end
         S_HEADER: begin
            if (xfer) begin
               state_d = S_DATA;
               idx_d   = 4'd0;
            end
         end
         S_DATA: begin
            if (xfer) begin
               // Index saturates at the last word; it never wraps inside a frame.
               if (idx_q == LAST_IDX) begin
                  state_d = S_CHECKSUM;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         S_CHECKSUM: begin
            if (xfer) begin
               state_d = S_IDLE;
               idx_d   = 4'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
         end
      endcase

      // Any request while a frame is in flight (including the cycle the
      // checksum leaves) is discarded but remembered until reset.
      if (read_req && (state_q != S_IDLE)) begin
         dropped_d = 1'b1;
      end
   end

   // Control registers: state, word index, clear pulse and sticky drop flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         idx_q     <= 4'd0;
         clear_q   <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         clear_q   <= clear_d;
         dropped_q <= dropped_d;
      end
   end

   // Snapshot and checksum registers; zeroed on reset so no stale data survives.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         csum_q <= 32'd0;
         for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
            snap_q[i] <= 32'd0;
         end
      end else begin
         csum_q <= csum_d;
         for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
            snap_q[i] <= snap_d[i];
         end
      end
   end

   // Select the snapshot word addressed by the current index.
   always_comb begin
      data_word = 32'd0;
      for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
         if (idx_q == 4'(i)) begin
            data_word = snap_q[i];
         end
      end
   end

   // Output word follows the state directly; it only changes on a transfer,
   // so it is stable for as long as the consumer stalls.
   always_comb begin
      out_data = 32'd0;
      case (state_q)
         S_HEADER:   out_data = HEADER_WORD;
         S_DATA:     out_data = data_word;
         S_CHECKSUM: out_data = csum_q;
         default:    out_data = 32'd0;
      endcase
   end

   assign busy           = (state_q != S_IDLE);
   assign out_valid      = (state_q != S_IDLE);
   assign out_last       = (state_q == S_CHECKSUM);
   assign clear_counters = clear_q;
   assign req_dropped    = dropped_q;

endmodule

// File: tb/tb_profiler_readout.sv
// Self-checking bench for profiler_readout: randomized counter values and
// downstream stalls, checked against a frame model built from plain XOR
// arithmetic over the counter array.
module tb_profiler_readout;

   localparam int          N   = 10;
   localparam logic [15:0] TAG = 16'hABAC;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*32-1:0] counters_in;
   logic            read_req;
   logic            clear_on_read;
   logic            clear_counters;
   logic [31:0]     out_data;
   logic            out_valid;
   logic            out_ready;
   logic            out_last;
   logic            busy;
   logic            req_dropped;

   profiler_readout #(
      .NUM_COUNTERS (N),
      .HEADER_TAG   (TAG)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .counters_in    (counters_in),
      .read_req       (read_req),
      .clear_on_read  (clear_on_read),
      .clear_counters (clear_counters),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_last       (out_last),
      .busy           (busy),
      .req_dropped    (req_dropped)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] cnt [N];
   logic [31:0] exp_q [$];
   logic [31:0] got_q [$];
   bit          last_q [$];
   int          hold_err;
   int          cyc_cnt;
   bit          timeout;
   int          clr_seen = 0;

   // Count every cycle in which the clear pulse is high.
   always @(negedge clk) if (clear_counters === 1'b1) clr_seen++;

   // Reference frame: header, counters in order, XOR of everything before.
   function automatic void build_expected();
      logic [31:0] hdr;
      logic [31:0] x;
      exp_q.delete();
      hdr = {TAG, 12'h000, 4'(N)};
      x   = hdr;
      exp_q.push_back(hdr);
      for (int i = 0; i < N; i++) begin
         exp_q.push_back(cnt[i]);
         x = x ^ cnt[i];
      end
      exp_q.push_back(x);
   endfunction

   task automatic drive_counters();
      for (int i = 0; i < N; i++) counters_in[32*i +: 32] = cnt[i];
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after the accept edge.
   task automatic start_frame();
      read_req = 1'b1;
      @(posedge clk);
      #1 read_req = 1'b0;
   endtask

   // Capture transferred words until out_last transfers or the budget expires.
   task automatic collect(input int ready_pct, input int max_cyc);
      bit          have_prev;
      bit          prev_v, prev_r, prev_l;
      logic [31:0] prev_d;
      got_q.delete();
      last_q.delete();
      hold_err  = 0;
      cyc_cnt   = 0;
      timeout   = 1'b1;
      have_prev = 1'b0;
      prev_v = 0; prev_r = 0; prev_l = 0; prev_d = '0;
      for (int c = 0; c < max_cyc; c++) begin
         out_ready = ($urandom_range(0, 99) < ready_pct);
         @(negedge clk);
         cyc_cnt++;
         if (have_prev && prev_v && !prev_r) begin
            if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l) hold_err++;
         end
         prev_v = out_valid; prev_r = out_ready; prev_d = out_data; prev_l = out_last;
         have_prev = 1'b1;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            got_q.push_back(out_data);
            last_q.push_back(out_last);
            if (out_last === 1'b1) begin
               timeout = 1'b0;
               @(posedge clk);
               #1;
               break;
            end
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, out_last, busy, clear_counters, req_dropped, out_data} !== 37'd0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b l=%b b=%b c=%b d=%b data=%h want all zero",
                  out_valid, out_last, busy, clear_counters, req_dropped, out_data);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got valid=%b busy=%b want 0 0", out_valid, busy);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic_frame();
      int clr_before;
      int nlast;
      for (int i = 0; i < N; i++) cnt[i] = 32'(i + 1);
      drive_counters();
      build_expected();
      clr_before = clr_seen;
      start_frame();
      collect(100, 40);
      checks++;
      if (timeout) begin errors++; $display("FAIL basic_timeout: no out_last within budget"); end
      checks++;
      if (got_q.size() != N + 2) begin
         errors++;
         $display("FAIL basic_count: got %0d words want %0d", got_q.size(), N + 2);
      end else begin
         for (int i = 0; i < N + 2; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL basic_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
         end
         checks++;
         if (got_q[0] !== 32'hABAC000A || got_q[N + 1] !== 32'hABAC0001) begin
            errors++;
            $display("FAIL basic_hdr_csum: got %h/%h want abac000a/abac0001", got_q[0], got_q[N + 1]);
         end
         nlast = 0;
         foreach (last_q[i]) if (last_q[i]) nlast++;
         checks++;
         if (nlast != 1 || last_q[N + 1] !== 1'b1) begin
            errors++;
            $display("FAIL basic_last: got %0d last flags want exactly 1 on final word", nlast);
         end
      end
      checks++;
      if (cyc_cnt != N + 2) begin
         errors++;
         $display("FAIL basic_bubbles: got %0d cycles want %0d", cyc_cnt, N + 2);
      end
      checks++;
      if (clr_seen != clr_before) begin
         errors++;
         $display("FAIL basic_no_clear: got %0d clear pulses want 0", clr_seen - clr_before);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_return_idle: got valid=%b busy=%b want 0 0", out_valid, busy);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < N; i++) cnt[i] = 32'(i + 1);
      drive_counters();
      build_expected();
      start_frame();
      collect(50, 400);
      checks++;
      if (timeout) begin errors++; $display("FAIL bp_timeout: no out_last within budget"); end
      checks++;
      if (hold_err != 0) begin
         errors++;
         $display("FAIL bp_hold: got %0d unstable stalled cycles want 0", hold_err);
      end
      checks++;
      if (got_q.size() != N + 2) begin
         errors++;
         $display("FAIL bp_count: got %0d words want %0d", got_q.size(), N + 2);
      end else begin
         for (int i = 0; i < N + 2; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== (i == N + 1)) begin
               errors++;
               $display("FAIL bp_word%0d: got %h last=%b want %h last=%b",
                        i, got_q[i], last_q[i], exp_q[i], (i == N + 1));
            end
         end
      end
   endtask

   task automatic test_snapshot_isolation();
      for (int i = 0; i < N; i++) cnt[i] = $urandom;
      drive_counters();
      build_expected();
      start_frame();
      counters_in = '1;
      collect(100, 40);
      checks++;
      if (timeout || got_q.size() != N + 2) begin
         errors++;
         $display("FAIL snap_count: got %0d words timeout=%b want %0d", got_q.size(), timeout, N + 2);
      end else begin
         for (int i = 0; i < N + 2; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL snap_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_clear_and_drop();
      int clr_before;
      int stray;
      apply_reset();
      for (int i = 0; i < N; i++) cnt[i] = $urandom;
      drive_counters();
      build_expected();
      out_ready     = 1'b0;
      clear_on_read = 1'b1;
      clr_before    = clr_seen;
      start_frame();
      clear_on_read = 1'b0;
      @(negedge clk);
      checks++;
      if (clear_counters !== 1'b1 || out_valid !== 1'b1 || out_data !== exp_q[0]) begin
         errors++;
         $display("FAIL clear_t1: got clr=%b valid=%b data=%h want 1 1 %h",
                  clear_counters, out_valid, out_data, exp_q[0]);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (clear_counters !== 1'b0) begin
         errors++;
         $display("FAIL clear_t2: got clr=%b want 0", clear_counters);
      end
      @(posedge clk);
      #1 read_req = 1'b1;
      @(posedge clk);
      #1 read_req = 1'b0;
      @(negedge clk);
      checks++;
      if (req_dropped !== 1'b1) begin
         errors++;
         $display("FAIL drop_flag: got %b want 1", req_dropped);
      end
      @(posedge clk);
      #1;
      collect(100, 40);
      checks++;
      if (timeout || got_q.size() != N + 2) begin
         errors++;
         $display("FAIL drop_count: got %0d words timeout=%b want %0d", got_q.size(), timeout, N + 2);
      end else begin
         for (int i = 0; i < N + 2; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL drop_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
         end
      end
      stray = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid !== 1'b0) stray++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL drop_no_frame: got %0d valid cycles want 0", stray);
      end
      checks++;
      if (clr_seen - clr_before != 1 || req_dropped !== 1'b1) begin
         errors++;
         $display("FAIL clear_total: got %0d pulses dropped=%b want 1 and 1",
                  clr_seen - clr_before, req_dropped);
      end
   endtask

   task automatic test_reset_midframe();
      int ntx;
      for (int i = 0; i < N; i++) cnt[i] = $urandom;
      drive_counters();
      out_ready = 1'b1;
      start_frame();
      ntx = 0;
      repeat (4) begin
         @(negedge clk);
         if (out_valid === 1'b1) ntx++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (ntx != 4) begin
         errors++;
         $display("FAIL rst_mid_pre: got %0d transfers want 4", ntx);
      end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, out_last, busy, clear_counters, req_dropped, out_data} !== 37'd0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got v=%b l=%b b=%b c=%b d=%b data=%h want all zero",
                  out_valid, out_last, busy, clear_counters, req_dropped, out_data);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      ntx = 0;
      repeat (3) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || out_last !== 1'b0) ntx++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (ntx != 0) begin
         errors++;
         $display("FAIL rst_mid_abort: got %0d active cycles want 0", ntx);
      end
      for (int i = 0; i < N; i++) cnt[i] = $urandom;
      drive_counters();
      build_expected();
      start_frame();
      collect(100, 40);
      checks++;
      if (timeout || got_q.size() != N + 2) begin
         errors++;
         $display("FAIL rst_mid_count: got %0d words timeout=%b want %0d", got_q.size(), timeout, N + 2);
      end else begin
         for (int i = 0; i < N + 2; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL rst_mid_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < N; i++) cnt[i] = $urandom;
         drive_counters();
         build_expected();
         start_frame();
         collect(int'($urandom_range(30, 100)), 400);
         checks++;
         if (timeout || hold_err != 0 || got_q.size() != N + 2) begin
            errors++;
            $display("FAIL b2b%0d_frame: got %0d words timeout=%b hold_err=%0d want %0d 0 0",
                     f, got_q.size(), timeout, hold_err, N + 2);
         end else begin
            for (int i = 0; i < N + 2; i++) begin
               checks++;
               if (got_q[i] !== exp_q[i] || last_q[i] !== (i == N + 1)) begin
                  errors++;
                  $display("FAIL b2b%0d_word%0d: got %h last=%b want %h last=%b",
                           f, i, got_q[i], last_q[i], exp_q[i], (i == N + 1));
               end
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      read_req      = 1'b0;
      clear_on_read = 1'b0;
      out_ready     = 1'b0;
      counters_in   = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_snapshot_isolation();
      test_clear_and_drop();
      test_reset_midframe();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/profiler_readout.md
PROFILER_READOUT -- requirements
Module: profiler_readout

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have NUM_COUNTERS, default 10, the number of 32-bit counter words in the snapshot (range 1..15).
REQ-002 The block SHALL have HEADER_TAG, default 16'hABAC, placed in the upper 16 bits of the header word.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset, which is synchronous and active-low.
REQ-005 The block SHALL have port counters_in, input, NUM_COUNTERS*32, the live profiler counters; word i is bits [32*i+31:32*i].
REQ-006 The block SHALL have port read_req, input, 1, a request to snapshot and stream the counters.
REQ-007 The block SHALL have port clear_on_read, input, 1, a request for a counter-clear pulse alongside the snapshot.
REQ-008 The block SHALL have port clear_counters, output, 1, a one-cycle pulse to the profiler to zero its counters.
REQ-009 The block SHALL have port out_data, output, 32, the stream data word.
REQ-010 The block SHALL have port out_valid, output, 1, indicating out_data is valid.
REQ-011 The block SHALL have port out_ready, input, 1, the downstream acceptance.
REQ-012 The block SHALL have port out_last, output, 1, marking the final word of the frame.
REQ-013 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-014 The block SHALL have port req_dropped, output, 1, a sticky flag: read_req was seen while busy.

Function
REQ-015 The block SHALL implement a state machine with states IDLE, HEADER, DATA and CHECKSUM.
REQ-016 In IDLE with read_req=1 at edge T, the block SHALL copy all counters_in words into snapshot registers at T and enter HEADER, so that out_valid=1 from T+1.
REQ-017 The block SHALL stream each frame as the header word {HEADER_TAG, 12'h0, NUM_COUNTERS[3:0]}, then snapshot words 0..NUM_COUNTERS-1 in order, then the checksum, for NUM_COUNTERS+2 words in total.
REQ-018 The checksum word SHALL be the bitwise XOR of the header word and all snapshot words.
REQ-019 A word SHALL transfer on any edge where out_valid=1 and out_ready=1; the block SHALL advance to the next word only on a transfer.
REQ-020 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable; out_valid SHALL NOT drop before its word transfers.
REQ-021 The block SHALL keep out_valid continuously high from the header through the checksum, so there are no bubbles when out_ready=1 and the frame takes exactly NUM_COUNTERS+2 cycles.
REQ-022 out_last SHALL be 1 only while the checksum word is presented.
REQ-023 On transfer of the checksum word, the block SHALL return to IDLE with out_valid=0 in the next cycle; a read_req in that same cycle SHALL be ignored and SHALL set req_dropped.
REQ-024 A read_req in any non-IDLE state SHALL be ignored for the current frame and SHALL set req_dropped; req_dropped SHALL clear only on reset.
REQ-025 Snapshot contents SHALL be unaffected by changes on counters_in after edge T.
REQ-026 clear_counters SHALL pulse high for exactly cycle T+1 when clear_on_read=1 at the accepting edge T, and SHALL never pulse otherwise.
REQ-027 The word index counter SHALL range 0..NUM_COUNTERS-1 and SHALL not wrap within a frame.

Reset
REQ-028 When rst_n=0 at a clock edge, the block SHALL enter IDLE and drive out_valid=0, out_last=0, out_data=0, busy=0, clear_counters=0 and req_dropped=0.
REQ-029 When rst_n=0 at a clock edge, the block SHALL zero the snapshot registers and the index counter.
REQ-030 A reset mid-frame SHALL abort the frame immediately, with no further words and no out_last.
REQ-031 With rst_n=1 after reset, the block SHALL need a new read_req to start a frame.

Verification
REQ-032 The bench SHALL check the basic frame: counters word i = i+1, out_ready held 1, one read_req pulse -> 12 consecutive words 0xABAC000A, 1..10, checksum 0xABAC000A^0x0000000B = 0xABAC0001, with out_last on word 12 only.
REQ-033 The bench SHALL check backpressure: out_ready toggled randomly -> same 12 words, each held stable until its transfer, with no loss or duplication.
REQ-034 The bench SHALL check snapshot isolation: counters_in changed to 0xFFFFFFFF the cycle after the accepting edge -> the frame still carries the old values.
REQ-035 The bench SHALL check clear and drop: read_req with clear_on_read=1 -> clear_counters high exactly one cycle at T+1; a second read_req mid-frame -> no new frame and req_dropped=1.
REQ-036 The bench SHALL check reset mid-frame: rst_n=0 during word 5 -> out_valid=0 on the next cycle, all outputs 0, and a new read_req restarts from the header.
